pattern_seq_detector: RTL and testbench

- Parametrised serial bit-pattern detector. It generalises the fixed 4-bit "1101" detector to a runtime-loadable pattern of up to PAT_W bits, with per-bit don't-care mask, programmable length, an overlap/non-overlap mode, input qualification, and a saturating match counter.
- Sits on a 1-bit serial stream inside control/protocol front-ends. Its detect pulse feeds downstream framers and interrupt logic.

---
 rtl/pattern_det_pkg.sv | 22 ++
 rtl/pattern_seq_detector_if.sv | 29 ++
 rtl/pattern_det_match.sv | 23 ++
 rtl/pattern_seq_detector.sv | 97 +++++++++
 tb/tb_pattern_seq_detector.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pattern_det_pkg.sv
// Shared types and helpers for the serial pattern detector.
// Config vectors are sized at PAT_MAX; a detector uses only the low PAT_W bits.
package pattern_det_pkg;

    localparam int PAT_MAX   = 32;
    localparam int LEN_MAX_W = $clog2(PAT_MAX + 1);

    typedef struct packed {
        logic [PAT_MAX-1:0]   pattern;
        logic [PAT_MAX-1:0]   mask;
        logic [LEN_MAX_W-1:0] len;
    } cfg_t;

    localparam cfg_t CFG_DEFAULT = '{pattern: '0, mask: '0, len: '0};

    function automatic logic [PAT_MAX-1:0] len_mask(input logic [LEN_MAX_W-1:0] len);
        logic [PAT_MAX-1:0] m;
        for (int i = 0; i < PAT_MAX; i++) m[i] = (i < int'(len));
        return m;
    endfunction

endpackage

// File: rtl/pattern_seq_detector_if.sv
// Config, serial stream and result signals of the pattern detector.
interface pattern_seq_detector_if #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 16
);
    localparam int LEN_W = $clog2(PAT_W + 1);

    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pattern;
    logic [PAT_W-1:0] cfg_mask;
    logic [LEN_W-1:0] cfg_len;
    logic             overlap_en;
    logic             clear;
    logic             in_valid;
    logic             in;
    logic             detected;
    logic [CNT_W-1:0] match_count;
    logic             count_sat;

    modport master (
        output cfg_load, cfg_pattern, cfg_mask, cfg_len, overlap_en, clear, in_valid, in,
        input  detected, match_count, count_sat
    );

    modport slave (
        input  cfg_load, cfg_pattern, cfg_mask, cfg_len, overlap_en, clear, in_valid, in,
        output detected, match_count, count_sat
    );
endinterface

// File: rtl/pattern_det_match.sv
// Combinational compare of the candidate history against the latched pattern.
module pattern_det_match
    import pattern_det_pkg::*;
#(
    parameter int PAT_W  = 8,
    parameter int FILL_W = $clog2(PAT_W + 1)
) (
    input  logic [PAT_W-1:0]  next_hist,
    input  cfg_t              cfg,
    input  logic [FILL_W-1:0] fill,
    output logic              hit
);
    logic [PAT_MAX-1:0] hist_ext;
    logic [PAT_MAX-1:0] diff;

    always_comb begin
        hist_ext              = '0;
        hist_ext[PAT_W-1:0]   = next_hist;
        diff                  = (hist_ext ^ cfg.pattern) & cfg.mask & len_mask(cfg.len);
        // fill counts bits held before this one, so the new bit makes fill+1
        hit = (int'(fill) + 1 >= int'(cfg.len)) && (diff == '0);
    end
endmodule

// File: rtl/pattern_seq_detector.sv
// Runtime-programmable serial pattern detector with masked compare,
// overlap control and a saturating match counter.
module pattern_seq_detector
    import pattern_det_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int CNT_W = 16
) (
    input logic                   clk,
    input logic                   reset_n,
    pattern_seq_detector_if.slave bus
);
    localparam int   LEN_W   = $clog2(PAT_W + 1);
    localparam cfg_t CFG_RST = '{pattern: CFG_DEFAULT.pattern, mask: CFG_DEFAULT.mask,
                                 len: LEN_MAX_W'(PAT_W)};

    cfg_t             cfg_q;
    cfg_t             cfg_in;
    logic [PAT_W-2:0] hist;
    logic [PAT_W-1:0] next_hist;
    logic [LEN_W-1:0] fill;
    logic [LEN_W-1:0] fill_inc;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_inc;
    logic             hit;
    logic             match;
    logic             sat;
    logic             detected_q;

    // Out-of-range lengths collapse to the full width at load time.
    always_comb begin
        cfg_in                    = CFG_DEFAULT;
        cfg_in.pattern[PAT_W-1:0] = bus.cfg_pattern;
        cfg_in.mask[PAT_W-1:0]    = bus.cfg_mask;
        cfg_in.len                = (bus.cfg_len == '0 || int'(bus.cfg_len) > PAT_W)
                                  ? LEN_MAX_W'(PAT_W) : LEN_MAX_W'(bus.cfg_len);
    end

    assign next_hist = {hist, bus.in};
    assign fill_inc  = (int'(fill) == PAT_W) ? fill : fill + LEN_W'(1);
    assign count_inc = count + CNT_W'(1);

    pattern_det_match #(.PAT_W(PAT_W), .FILL_W(LEN_W)) u_match (
        .next_hist (next_hist),
        .cfg       (cfg_q),
        .fill      (fill),
        .hit       (hit)
    );

    // clear and cfg_load both swallow a same-cycle data bit.
    assign match = bus.in_valid && hit && !bus.clear && !bus.cfg_load;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)          cfg_q <= CFG_RST;
        else if (bus.cfg_load) cfg_q <= cfg_in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist <= '0;
            fill <= '0;
        end else if (bus.clear || bus.cfg_load) begin
            hist <= '0;
            fill <= '0;
        end else if (bus.in_valid) begin
            if (match && !bus.overlap_en) begin
                hist <= '0;
                fill <= '0;
            end else begin
                hist <= next_hist[PAT_W-2:0];
                fill <= fill_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (bus.clear) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (match && !(&count)) begin
            count <= count_inc;
            if (&count_inc) sat <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) detected_q <= 1'b0;
        else          detected_q <= match;
    end

    assign bus.detected    = detected_q;
    assign bus.match_count = count;
    assign bus.count_sat   = sat;
endmodule

// File: tb/tb_pattern_seq_detector.sv
// Bench for pattern_seq_detector: directed cases plus random traffic against a
// queue-based model; two instances differ only in counter width.
module tb_pattern_seq_detector;
    localparam int PAT_W = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cfg_load = 1'b0;
    logic [7:0] cfg_pattern = '0;
    logic [7:0] cfg_mask = '0;
    logic [3:0] cfg_len = '0;
    logic       overlap_en = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    pattern_seq_detector_if #(.PAT_W(PAT_W), .CNT_W(16)) bus ();
    pattern_seq_detector_if #(.PAT_W(PAT_W), .CNT_W(2))  bus_s ();

    assign bus.cfg_load      = cfg_load;
    assign bus.cfg_pattern   = cfg_pattern;
    assign bus.cfg_mask      = cfg_mask;
    assign bus.cfg_len       = cfg_len;
    assign bus.overlap_en    = overlap_en;
    assign bus.clear         = clear;
    assign bus.in_valid      = in_valid;
    assign bus.in            = in_bit;
    assign bus_s.cfg_load    = cfg_load;
    assign bus_s.cfg_pattern = cfg_pattern;
    assign bus_s.cfg_mask    = cfg_mask;
    assign bus_s.cfg_len     = cfg_len;
    assign bus_s.overlap_en  = overlap_en;
    assign bus_s.clear       = clear;
    assign bus_s.in_valid    = in_valid;
    assign bus_s.in          = in_bit;

    pattern_seq_detector #(.PAT_W(PAT_W), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus));
    pattern_seq_detector #(.PAT_W(PAT_W), .CNT_W(2)) dut_s (
        .clk(clk), .reset_n(reset_n), .bus(bus_s));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the received bits since the last clear/load/non-overlap match.
    bit      q[$];
    logic [7:0] m_pat, m_mask;
    int      m_len;
    longint  m_cnt;
    bit      m_det;

    function automatic bit model_hit();
        if (q.size() < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++)
            if (m_mask[k] && (q[q.size() - 1 - k] != m_pat[k])) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [63:0] sat_val(input longint c, input longint maxv);
        return 64'((c > maxv) ? maxv : c);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            m_cnt = 0; m_det = 0; m_pat = '0; m_mask = '0; m_len = PAT_W;
        end else begin
            m_det = 0;
            if (clear) begin
                q.delete();
                m_cnt = 0;
            end else if (cfg_load) begin
                q.delete();
            end else if (in_valid) begin
                q.push_back(in_bit);
                if (q.size() > PAT_W) void'(q.pop_front());
                if (model_hit()) begin
                    m_det = 1;
                    m_cnt++;
                    if (!overlap_en) q.delete();
                end
            end
            if (cfg_load) begin
                m_pat  = cfg_pattern;
                m_mask = cfg_mask;
                m_len  = (cfg_len == 0 || cfg_len > PAT_W) ? PAT_W : int'(cfg_len);
            end
        end
    end

    always @(negedge clk) begin
        check("detected",     64'(bus.detected),      64'(m_det));
        check("detected_s",   64'(bus_s.detected),    64'(m_det));
        check("match_count",  64'(bus.match_count),   sat_val(m_cnt, 65535));
        check("count_sat",    64'(bus.count_sat),     64'(m_cnt >= 65535));
        check("match_count_s",64'(bus_s.match_count), sat_val(m_cnt, 3));
        check("count_sat_s",  64'(bus_s.count_sat),   64'(m_cnt >= 3));
    end

    task automatic send(input bit b);
        in_valid = 1'b1; in_bit = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic load(input logic [7:0] p, input logic [7:0] m, input logic [3:0] l);
        cfg_pattern = p; cfg_mask = m; cfg_len = l; cfg_load = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    bit stream[7]   = '{1, 1, 0, 1, 1, 0, 1};
    bit exp_ov[7]   = '{0, 0, 0, 1, 0, 0, 1};
    bit exp_nov[7]  = '{0, 0, 0, 1, 0, 0, 0};
    bit dc_in[6]    = '{1, 0, 1, 1, 1, 1};
    bit dc_exp[6]   = '{0, 0, 1, 0, 1, 1};
    int sat_exp[5]  = '{1, 2, 3, 3, 3};

    initial begin
        repeat (3) @(negedge clk);
        check("reset_detected", 64'(bus.detected), 64'(0));
        check("reset_count", 64'(bus.match_count), 64'(0));
        reset_n = 1'b1;
        @(negedge clk);

        // Reset config: all-don't-care over full width, first hit on bit 8.
        overlap_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(1'($urandom_range(0, 1)));
            check("reset_cfg_fill", 64'(bus.detected), 64'(i == 7));
        end

        do_clear();
        load(8'b0000_1101, 8'h0F, 4'd4);
        for (int i = 0; i < 7; i++) begin
            send(stream[i]);
            check("ov_det", 64'(bus.detected), 64'(exp_ov[i]));
        end
        check("ov_count", 64'(bus.match_count), 64'(2));

        do_clear();
        overlap_en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            send(stream[i]);
            check("nov_det", 64'(bus.detected), 64'(exp_nov[i]));
        end
        check("nov_count", 64'(bus.match_count), 64'(1));

        do_clear();
        overlap_en = 1'b1;
        load(8'b101, 8'b101, 4'd3);
        for (int i = 0; i < 6; i++) begin
            send(dc_in[i]);
            check("dc_det", 64'(bus.detected), 64'(dc_exp[i]));
        end
        check("dc_count", 64'(bus.match_count), 64'(3));

        do_clear();
        load(8'b0000_1101, 8'h0F, 4'd4);
        send(1); send(1);
        repeat (3) begin
            @(negedge clk);
            check("gap_idle", 64'(bus.detected), 64'(0));
        end
        send(0);
        check("gap_det0", 64'(bus.detected), 64'(0));
        send(1);
        check("gap_det1", 64'(bus.detected), 64'(1));
        check("gap_count", 64'(bus.match_count), 64'(1));

        send(1); send(1); send(0);
        load(8'b0000_1101, 8'h0F, 4'd4);
        send(1);
        check("load_flush", 64'(bus.detected), 64'(0));
        send(1); send(1); send(0); send(1);
        check("load_rematch", 64'(bus.detected), 64'(1));
        check("load_keeps_count", 64'(bus.match_count), 64'(2));

        clear = 1'b1;
        load(8'b11, 8'b11, 4'd2);
        clear = 1'b0;
        check("clr_load_count", 64'(bus.match_count), 64'(0));
        check("clr_load_sat", 64'(bus_s.count_sat), 64'(0));
        send(1); send(1);
        check("clr_load_cfg", 64'(bus.detected), 64'(1));

        do_clear();
        load(8'h00, 8'h00, 4'd1);
        for (int i = 0; i < 5; i++) begin
            send(1'($urandom_range(0, 1)));
            check("sat_count", 64'(bus_s.match_count), 64'(sat_exp[i]));
            check("sat_flag", 64'(bus_s.count_sat), 64'(i >= 2));
            check("wide_count", 64'(bus.match_count), 64'(i + 1));
        end

        in_valid = 1'b1; in_bit = 1'b1;
        @(posedge clk); #2;
        check("pre_reset_det", 64'(bus.detected), 64'(1));
        reset_n = 1'b0;
        #1;
        check("async_det", 64'(bus.detected), 64'(0));
        check("async_count", 64'(bus.match_count), 64'(0));
        check("async_sat", 64'(bus_s.count_sat), 64'(0));
        @(negedge clk);
        in_valid = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);

        for (int n = 0; n < 3000; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            clear    = (r < 2);
            cfg_load = (r >= 2 && r < 7) || (r == 0);
            if (cfg_load) begin
                cfg_len     = 4'($urandom_range(0, 15));
                cfg_pattern = 8'($urandom);
                cfg_mask    = 8'($urandom & $urandom);
            end
            if ($urandom_range(0, 9) == 0) overlap_en = 1'($urandom_range(0, 1));
            in_valid = ($urandom_range(0, 99) < 75);
            in_bit   = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        clear = 1'b0; cfg_load = 1'b0; in_valid = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
